// File: rtl/prio_mem_pkg.sv
// Shared types and helpers for the priority-arbitrated scratch memory.
package prio_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // A single requester still needs a 1-bit channel index on the response.
  function automatic int ch_w(input int nch);
    return (nch <= 1) ? 1 : $clog2(nch);
  endfunction

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/prio_arb.sv
// Fixed-priority arbiter: the lowest-index active request wins while en is high.
module prio_arb
  import prio_mem_pkg::*;
#(
  parameter  int NCH  = 3,
  localparam int CH_W = ch_w(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic            en,
  output logic [NCH-1:0]  gnt,
  output logic [CH_W-1:0] gnt_idx
);

  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (en && req[i] && !found) begin
        gnt[i]  = 1'b1;
        gnt_idx = CH_W'(i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_mem_ctrl.sv
// Single-port scratch memory shared by NCH fixed-priority requesters, with a
// zeroing sweep after reset and on clr_req.
//   state | meaning
//   CLEAR | sweep writes zero to mem[cnt], all requesters held off, busy=1
//   RUN   | one granted transfer per cycle, channel 0 highest priority
module prio_mem_ctrl
  import prio_mem_pkg::*;
#(
  parameter  int DATA_W     = 4,
  parameter  int ADDR_W     = 10,
  parameter  int NCH        = 3,
  parameter  int INIT_CLEAR = 1,
  localparam int CH_W       = ch_w(NCH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        req_valid,
  output logic [NCH-1:0]        req_ready,
  input  logic [NCH-1:0]        req_we,
  input  logic [NCH*ADDR_W-1:0] req_addr,
  input  logic [NCH*DATA_W-1:0] req_wdata,
  input  logic                  clr_req,
  output logic                  rsp_valid,
  output logic [CH_W-1:0]       rsp_ch,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  busy
);

  localparam int DEPTH = depth_of(ADDR_W);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt, cnt_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                arb_en;
  logic [NCH-1:0]      gnt;
  logic [CH_W-1:0]     gnt_idx;
  logic                xfer;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // clr_req wins over any request in the cycle it is seen.
  assign arb_en = (state == RUN) && !clr_req;

  prio_arb #(.NCH(NCH)) u_arb (
    .req     (req_valid),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign busy      = (state == CLEAR);

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt[i]) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (&cnt) state_nxt = RUN;
      end
      RUN: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= (INIT_CLEAR != 0) ? CLEAR : RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[cnt] <= '0;
    else if (xfer && sel_we)
      mem[sel_addr] <= sel_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_ch    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= xfer && !sel_we;
      if (xfer && !sel_we) begin
        rsp_data <= mem[sel_addr];
        rsp_ch   <= gnt_idx;
      end
    end
  end

endmodule
